// File: rtl/sobel_stream_if.sv
// Pixel stream bundle between the HDMI input side and the Sobel filter outputs.
interface sobel_stream_if;
  logic        in_valid;
  logic        in_sof;
  logic        in_eol;
  logic [23:0] in_pixel;
  logic        out_valid;
  logic [23:0] out_pixel;
  logic        proj_pixel;

  // Push-only stream: a pixel transfers on every cycle its valid is high; there is no ready/backpressure.
  modport master (output in_valid, in_sof, in_eol, in_pixel,
                  input  out_valid, out_pixel, proj_pixel);
  modport slave  (input  in_valid, in_sof, in_eol, in_pixel,
                  output out_valid, out_pixel, proj_pixel);
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: two line buffers plus shift registers form the
// window; stage 1 computes gradients, stage 2 clamps, maps and thresholds.
module sobel_stream_filter #(
  parameter int         IMG_WIDTH      = 640,
  parameter int         COL_W          = 10,
  parameter logic [7:0] DEFAULT_THRESH = 8'd60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [7:0]    threshold,
  sobel_stream_if.slave stream,
  output logic          status
);
  localparam int               AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] ROW_MAX  = '1;

  logic [COL_W-1:0] col, row, cur_col, cur_row;
  logic [1:0]       mode_q, mode_eff;
  logic [7:0]       thr_q, thr_eff;
  logic             en_q, en_eff, armed, take, border;
  logic [7:0]       luma, rd1, rd2;
  logic [AW-1:0]    addr;
  logic [7:0]       lb1 [IMG_WIDTH];
  logic [7:0]       lb2 [IMG_WIDTH];
  logic [1:0][7:0]  top_sr, mid_sr, bot_sr;
  logic signed [10:0] gx, gy;

  // The sof pixel already belongs to the new frame, so it uses the new controls.
  assign take     = stream.in_valid & stream.in_sof;
  assign cur_col  = stream.in_sof ? '0 : col;
  assign cur_row  = stream.in_sof ? '0 : row;
  assign mode_eff = take ? mode : mode_q;
  assign thr_eff  = take ? threshold : thr_q;
  assign en_eff   = take ? en : en_q;
  assign luma     = stream.in_pixel[7:0];
  assign addr     = cur_col[AW-1:0];
  assign rd1      = lb1[addr];
  assign rd2      = lb2[addr];
  assign border   = (cur_row < COL_W'(2)) || (cur_col < COL_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (stream.in_valid) begin
      if (stream.in_eol || cur_col == LAST_COL) begin
        col <= '0;
        row <= (cur_row != ROW_MAX) ? cur_row + 1'b1 : cur_row;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      thr_q  <= DEFAULT_THRESH;
      en_q   <= 1'b0;
      armed  <= 1'b0;
    end else if (take) begin
      mode_q <= mode;
      thr_q  <= threshold;
      en_q   <= en;
      armed  <= 1'b1;
    end
  end

  // lb1 holds row r-1, lb2 row r-2; both are read and written at the current column.
  always_ff @(posedge clk) begin
    if (stream.in_valid) begin
      lb1[addr] <= luma;
      lb2[addr] <= rd1;
    end
  end

  // Index [1] is column c-2, index [0] is column c-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_sr <= '0;
      mid_sr <= '0;
      bot_sr <= '0;
    end else if (stream.in_valid) begin
      top_sr <= {top_sr[0], rd2};
      mid_sr <= {mid_sr[0], rd1};
      bot_sr <= {bot_sr[0], luma};
    end
  end

  function automatic logic signed [10:0] sx(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  assign gx = (sx(rd2) - sx(top_sr[1])) + ((sx(rd1) - sx(mid_sr[1])) <<< 1)
            + (sx(luma) - sx(bot_sr[1]));
  assign gy = (sx(top_sr[1]) - sx(bot_sr[1])) + ((sx(top_sr[0]) - sx(bot_sr[0])) <<< 1)
            + (sx(rd2) - sx(luma));

  logic               s1_valid, s1_border, s1_pass;
  logic signed [10:0] s1_gx, s1_gy;
  logic [23:0]        s1_pix;
  logic [1:0]         s1_mode;
  logic [7:0]         s1_thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b0;
      s1_pass   <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
      s1_pix    <= '0;
      s1_mode   <= 2'd0;
      s1_thr    <= '0;
    end else begin
      s1_valid <= stream.in_valid & (armed | stream.in_sof);
      if (stream.in_valid) begin
        s1_border <= border;
        s1_pass   <= ~en_eff | (mode_eff == 2'd0);
        s1_gx     <= gx;
        s1_gy     <= gy;
        s1_pix    <= stream.in_pixel;
        s1_mode   <= mode_eff;
        s1_thr    <= thr_eff;
      end
    end
  end

  function automatic logic [7:0] clamp(input logic [10:0] v);
    return (v > 11'd255) ? 8'hFF : v[7:0];
  endfunction

  logic signed [10:0] ngx, ngy;
  logic [9:0]         ax, ay;
  logic [10:0]        sum;
  logic [7:0]         mag, cr, cg;
  logic               hit;
  logic [23:0]        mapped;

  always_comb begin
    ngx    = -s1_gx;
    ngy    = -s1_gy;
    ax     = s1_gx[10] ? ngx[9:0] : s1_gx[9:0];
    ay     = s1_gy[10] ? ngy[9:0] : s1_gy[9:0];
    sum    = {1'b0, ax} + {1'b0, ay};
    mag    = s1_border ? 8'd0 : clamp(sum);
    cr     = s1_border ? 8'd0 : clamp({1'b0, ax});
    cg     = s1_border ? 8'd0 : clamp({1'b0, ay});
    hit    = mag > s1_thr;
    mapped = s1_pix;
    case (s1_mode)
      2'd1:    mapped = {mag, mag, mag};
      2'd2:    mapped = hit ? 24'hFFFFFF : 24'h000000;
      2'd3:    mapped = {cr, cg, mag};
      default: mapped = s1_pix;
    endcase
    if (s1_pass) mapped = s1_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream.out_valid  <= 1'b0;
      stream.out_pixel  <= '0;
      stream.proj_pixel <= 1'b0;
      status            <= 1'b0;
    end else begin
      status           <= en;
      stream.out_valid <= s1_valid;
      if (s1_valid) begin
        stream.out_pixel  <= mapped;
        stream.proj_pixel <= hit & ~s1_pass;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: frame-level reference model with per-cycle compare,
// directed pattern frames with literal expectations, and randomized frames.
module tb_sobel_stream_filter;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic       status;
  logic       checking = 1'b0;
  logic       rand_hi = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [24:0] obs_q[$];

  sobel_stream_if bus();

  sobel_stream_filter #(.IMG_WIDTH(W), .COL_W(10), .DEFAULT_THRESH(8'd60)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .threshold(threshold),
    .stream(bus), .status(status));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: whole-frame luma image, window read straight from it.
  int          m_row, m_col;
  int          img [32][W];
  logic [1:0]  m_mode;
  logic [7:0]  m_thr;
  logic        m_en, m_armed;
  logic        s1_v, s1_proj, e_valid, e_proj, e_status;
  logic [23:0] s1_pix, e_pix;

  function automatic int px(input int r, input int c);
    return img[r % 32][c];
  endfunction
  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction
  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_output(input logic [23:0] pix, output logic [23:0] o, output logic p);
    int gx, gy, ax, ay, mag, r, c;
    r = m_row; c = m_col; gx = 0; gy = 0;
    if (r >= 2 && c >= 2) begin
      gx = (px(r-2, c) - px(r-2, c-2)) + 2 * (px(r-1, c) - px(r-1, c-2)) + (px(r, c) - px(r, c-2));
      gy = (px(r-2, c-2) - px(r, c-2)) + 2 * (px(r-2, c-1) - px(r, c-1)) + (px(r-2, c) - px(r, c));
    end
    ax = iabs(gx); ay = iabs(gy); mag = sat(ax + ay);
    p = (mag > int'(m_thr));
    case (m_mode)
      2'd1:    o = {3{8'(mag)}};
      2'd2:    o = p ? 24'hFFFFFF : 24'h000000;
      default: o = {8'(sat(ax)), 8'(sat(ay)), 8'(mag)};
    endcase
    if (!m_en || m_mode == 2'd0) begin
      o = pix;
      p = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_row = 0; m_col = 0; m_mode = 2'd0; m_thr = 8'd60; m_en = 1'b0; m_armed = 1'b0;
      s1_v = 1'b0; s1_pix = '0; s1_proj = 1'b0;
      e_valid = 1'b0; e_pix = '0; e_proj = 1'b0; e_status = 1'b0;
    end else begin
      e_status = en;
      e_valid  = s1_v;
      if (s1_v) begin
        e_pix  = s1_pix;
        e_proj = s1_proj;
      end
      s1_v = 1'b0;
      if (bus.in_valid) begin
        if (bus.in_sof) begin
          m_row = 0; m_col = 0; m_mode = mode; m_thr = threshold; m_en = en; m_armed = 1'b1;
        end
        img[m_row % 32][m_col] = int'(bus.in_pixel[7:0]);
        if (m_armed) begin
          s1_v = 1'b1;
          model_output(bus.in_pixel, s1_pix, s1_proj);
        end
        if (bus.in_eol || m_col == W - 1) begin
          m_col = 0;
          if (m_row < 1023) m_row++;
        end else begin
          m_col++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("out_pixel", 32'(bus.out_pixel), 32'(e_pix));
      check("proj_pixel", 32'(bus.proj_pixel), 32'(e_proj));
      check("status", 32'(status), 32'(e_status));
    end
    if (bus.out_valid === 1'b1) obs_q.push_back({bus.proj_pixel, bus.out_pixel});
  end

  function automatic logic [15:0] hi_bytes();
    return rand_hi ? 16'($urandom) : 16'hA55A;
  endfunction

  function automatic logic [7:0] pattern(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'(10 * c);
      1:       return 8'(10 * r);
      2:       return (c >= 4) ? 8'd255 : 8'd0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic put_pixel(input logic [23:0] pix, input logic sof, input logic eol, input int gap);
    bus.in_valid = 1'b1; bus.in_sof = sof; bus.in_eol = eol; bus.in_pixel = pix;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eol = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // gap < 0 selects a random 0..2 idle cycles after each pixel.
  task automatic send_span(input int kind, input int first, input int last, input logic sof, input int gap);
    for (int i = first; i <= last; i++) begin
      put_pixel({hi_bytes(), pattern(kind, i / W, i % W)}, sof && (i == first), (i % W) == W - 1,
                (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  task automatic set_ctrl(input logic e, input logic [1:0] m, input logic [7:0] t);
    en = e; mode = m; threshold = t;
  endtask

  task automatic flush();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic check_ramp_frame(input string nm);
    check({nm, "_count"}, 32'(obs_q.size()), 32'd32);
    if (obs_q.size() == 32) begin
      for (int k = 0; k < 32; k++) begin
        check($sformatf("%s_r%0d_c%0d", nm, k / W, k % W), 32'(obs_q[k]),
              ((k / W) >= 2 && (k % W) >= 2) ? 32'h1505050 : 32'h0);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eol = 1'b0; bus.in_pixel = '0;
    set_ctrl(1'b1, 2'd1, 8'd60);
    @(negedge clk);
    checking = 1'b1;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pixel", 32'(bus.out_pixel), 32'd0);
    check("reset_proj", 32'(bus.proj_pixel), 32'd0);
    check("reset_status", 32'(status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Horizontal ramp, gray magnitude.
    obs_q.delete();
    send_span(0, 0, 31, 1'b1, 0);
    flush();
    check_ramp_frame("t1");

    // Vertical ramp, split mode, threshold equal to magnitude.
    set_ctrl(1'b1, 2'd3, 8'd80);
    obs_q.delete();
    send_span(1, 0, 31, 1'b1, 0);
    flush();
    check("t2_count", 32'(obs_q.size()), 32'd32);
    check("t2_r2c3", 32'(obs_q[2*W+3]), 32'h0005050);
    check("t2_r1c3", 32'(obs_q[1*W+3]), 32'h0);

    // Vertical step, binary mode.
    set_ctrl(1'b1, 2'd2, 8'd60);
    obs_q.delete();
    send_span(2, 0, 31, 1'b1, 0);
    flush();
    check("t3_r2c4", 32'(obs_q[2*W+4]), 32'h1FFFFFF);
    check("t3_r3c5", 32'(obs_q[3*W+5]), 32'h1FFFFFF);
    check("t3_r3c6", 32'(obs_q[3*W+6]), 32'h0);
    check("t3_r2c3", 32'(obs_q[2*W+3]), 32'h0);

    // Mode change mid-frame is ignored until the next sof.
    set_ctrl(1'b1, 2'd1, 8'd60);
    obs_q.delete();
    send_span(0, 0, 15, 1'b1, 0);
    set_ctrl(1'b1, 2'd2, 8'd60);
    send_span(0, 16, 31, 1'b0, 0);
    flush();
    check("t4_mid_r3c4", 32'(obs_q[3*W+4]), 32'h1505050);
    obs_q.delete();
    send_span(0, 0, 31, 1'b1, 0);
    flush();
    check("t4_next_r2c4", 32'(obs_q[2*W+4]), 32'h1FFFFFF);
    check("t4_next_r1c4", 32'(obs_q[1*W+4]), 32'h0);

    // Bypass latched at sof; raising en mid-frame has no effect.
    set_ctrl(1'b0, 2'd1, 8'd60);
    obs_q.delete();
    send_span(0, 0, 15, 1'b1, 0);
    en = 1'b1;
    send_span(0, 16, 31, 1'b0, 0);
    flush();
    check("t5_k0", 32'(obs_q[0]), 32'h0A55A00);
    check("t5_k19", 32'(obs_q[19]), 32'h0A55A1E);
    check("t5_k31", 32'(obs_q[31]), 32'h0A55A46);

    // Every-other-cycle input gives the same results as the continuous case.
    set_ctrl(1'b1, 2'd1, 8'd60);
    obs_q.delete();
    send_span(0, 0, 31, 1'b1, 1);
    flush();
    check_ramp_frame("t6");

    // Asynchronous reset in the middle of row 2.
    obs_q.delete();
    send_span(0, 0, 19, 1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t7_rst_pixel", 32'(bus.out_pixel), 32'd0);
    check("t7_rst_proj", 32'(bus.proj_pixel), 32'd0);
    obs_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_span(0, 20, 31, 1'b0, 0);
    flush();
    check("t7_dropped", 32'(obs_q.size()), 32'd0);
    send_span(0, 0, 31, 1'b1, 0);
    flush();
    check_ramp_frame("t7_after");

    // Randomized frames with random gaps, mid-frame control churn and truncated frames.
    rand_hi = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int npix, mid;
      set_ctrl($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      npix = W * int'($urandom_range(3, 5));
      if ($urandom_range(0, 3) == 0) npix = int'($urandom_range(2 * W, npix - 1));
      mid = int'($urandom_range(0, npix - 2));
      send_span(3, 0, mid, 1'b1, -1);
      set_ctrl($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      send_span(3, mid + 1, npix - 1, 1'b0, -1);
    end
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Streaming 3x3 Sobel edge filter with internal line buffers. It accepts one raster-order 24-bit pixel per valid cycle and builds the 3x3 window itself, so upstream no longer supplies three row vectors.
- Adds runtime mode select, a programmable threshold, frame-synchronised control latching, border masking and a valid strobe.
- Sits between the HDMI input pixel stream and both the HDMI output and the projector 1-bit output.

Parameters:
- IMG_WIDTH, 640, active pixels per line; line buffer depth.
- COL_W, 10, column/row counter width; must satisfy 2^COL_W >= IMG_WIDTH.
- DEFAULT_THRESH, 60, threshold loaded at reset.

Ports:
- clk  in  1  pixel-domain clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  0 = bypass (passthrough regardless of mode).
- mode  in  2  0 passthrough, 1 gray magnitude, 2 binary, 3 split (|gx| R, |gy| G, clamped sum B).
- threshold  in  8  binary/projector threshold.
- in_valid  in  1  input pixel strobe.
- in_sof  in  1  qualifies first pixel of frame; valid only with in_valid.
- in_eol  in  1  qualifies last pixel of line; valid only with in_valid.
- in_pixel  in  24  RGB; luma taken from [7:0].
- out_valid  out  1  output pixel strobe.
- out_pixel  out  24  filtered pixel.
- proj_pixel  out  1  thresholded edge bit.
- status  out  1  registered copy of en.

Behaviour:
- Reset state: all outputs 0; counters 0; latched mode = 0; latched threshold = DEFAULT_THRESH; pipeline valids cleared. Line buffer RAM contents are not reset.
- Counters:
  - col increments on each in_valid.
  - col wraps to 0 and row increments when in_eol is set or col == IMG_WIDTH-1, whichever occurs first.
  - in_sof forces that pixel to (row 0, col 0).
  - row saturates at 2^COL_W-1.
- Control latch: mode, threshold and en are sampled only on an in_valid & in_sof cycle and held for the whole frame. Mid-frame changes are ignored until the next sof.
- Window:
  - Two line buffers of IMG_WIDTH x 8 hold rows r-1 and r-2, read and written at col.
  - Three 3-tap shift registers form p0..p8 on each in_valid: p0 is top-left (r-2,c-2), p8 is bottom-right (r,c).
- Arithmetic:
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6); gy = (p0-p6) + 2(p1-p7) + (p2-p8).
  - Both are signed 11-bit, range ±1020.
  - abs values are unsigned 10-bit; sum is unsigned 11-bit.
  - mag = 255 if sum > 255, else sum[7:0]. Per-channel clamps in mode 3 follow the same rule.
- Output mapping:
  - Each input produces exactly one output, for centre pixel (r-1,c-1).
  - Border masking: if row < 2 or col < 2, mag and channels are forced to 0.
  - Mode 1: out_pixel = {mag, mag, mag}.
  - Mode 2: out_pixel = 24'hFFFFFF if mag > thr, else 0.
  - proj_pixel = (mag > thr), strictly greater, in all non-passthrough modes. It is 0 in passthrough.
- Passthrough (mode 0 or latched en = 0): out_pixel = in_pixel delayed by the pipeline latency, aligned to the input pixel, not the centre.
- Latency: out_valid asserts exactly 2 clk after the in_valid cycle.
  - Stage 1: window and gradients.
  - Stage 2: clamp, mapping and threshold.
- No backpressure. Gaps in in_valid stall nothing; outputs hold their last value while out_valid = 0.
- Reset mid-frame clears all pipeline stages immediately. Output resumes only after the next in_sof; in_valid pixels before that are dropped (out_valid stays 0).
- An in_sof arriving mid-line restarts counting. The stale line buffer data is masked by the row < 2 rule.

Test Plan:
- IMG_WIDTH=8, mode 1, en=1, 4 rows with pixel[7:0] = 10*col -> for row ≥ 2 and col ≥ 2 out_pixel = 0x505050 (80), proj_pixel = 1 (thr 60); all other positions give 0; out_valid exactly 2 cycles after each in_valid.
- Vertical ramp pixel = 10*row, mode 3 -> interior out_pixel = {8'd0, 8'd80, 8'd80}; thr = 80 -> proj_pixel = 0 (strict >).
- Vertical step 0 | 255 (cols 0-3 = 0, cols 4-7 = 255), mode 2 -> cols 4,5 of rows ≥ 2 give sum 1020, clamped 255 -> 0xFFFFFF, proj 1; flat areas give 0.
- mode changed 1 -> 2 mid-frame -> no output change until the next in_sof; after it, binary output. en = 0 at sof -> out_pixel equals in_pixel delayed 2 cycles, proj_pixel = 0.
- in_valid toggled every other cycle -> identical result sequence to the continuous case, with out_valid following the gaps.
- rst_n pulsed low mid-row 2 -> outputs 0 asynchronously, out_valid = 0 until the next in_sof; the first post-sof rows 0-1 output 0.
